// File: rtl/mips_core_pkg.sv
// Shared types for the MIPS core: register-file image, checkpoint tag and
// the checkpoint restore handshake states.
package mips_core_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_REGS   = 32;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_TAG_WIDTH  = $clog2(DEF_DEPTH);

   // Full architectural register file image, register 0 in the low slot.
   typedef logic [DEF_NUM_REGS-1:0][DEF_DATA_WIDTH-1:0] regfile_t;

   // Identifies one checkpoint slot.
   typedef logic [DEF_TAG_WIDTH-1:0] ckpt_tag_t;

   // IDLE accepts takes and restores; HOLD presents a restored image until acked.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } ckpt_state_e;

endpackage

// File: rtl/ckpt_tag_live.sv
// Decides whether a checkpoint tag names a live slot of the circular
// buffer, i.e. lies in [head, tail) modulo DEPTH, or the buffer is full.
module ckpt_tag_live #(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = $clog2(DEPTH)
) (
   input  logic [TAG_WIDTH-1:0] head,
   input  logic [TAG_WIDTH-1:0] tail,
   input  logic [TAG_WIDTH:0]   count,
   input  logic [TAG_WIDTH-1:0] tag,
   output logic                 live
);

   localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH+1)'(DEPTH);

   // head == tail is ambiguous; count resolves it (full -> all live, else none).
   always_comb begin
      live = 1'b0;
      if (count == FULL_COUNT) begin
         live = 1'b1;
      end else if (head < tail) begin
         live = (tag >= head) && (tag < tail);
      end else if (head > tail) begin
         live = (tag >= head) || (tag < tail);
      end
   end

endmodule

// File: rtl/register_checkpoint_buffer.sv
// Circular buffer of register-file checkpoints, one per unresolved branch.
// Takes allocate at tail, releases free the oldest at head, and a restore
// returns any live checkpoint while discarding it and everything younger.
module register_checkpoint_buffer
   import mips_core_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_in,
   input  logic                                take_valid,
   output logic                                take_ready,
   output logic [TAG_WIDTH-1:0]                take_tag,
   input  logic                                release_valid,
   input  logic                                restore_valid,
   input  logic [TAG_WIDTH-1:0]                restore_tag,
   input  logic                                restore_ack,
   output logic                                restore_done,
   output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_restore,
   output logic [TAG_WIDTH:0]                  count,
   output logic                                full,
   output logic                                empty,
   output logic                                err_bad_tag,
   output logic                                err_underflow
);

   localparam logic [TAG_WIDTH:0]   FULL_COUNT = (TAG_WIDTH+1)'(DEPTH);
   localparam logic [TAG_WIDTH:0]   ONE_CNT    = (TAG_WIDTH+1)'(1);
   localparam logic [TAG_WIDTH-1:0] ONE_TAG    = TAG_WIDTH'(1);

   ckpt_state_e state, state_n;

   logic [TAG_WIDTH-1:0] head, tail;
   logic [TAG_WIDTH-1:0] head_n, tail_n;
   logic [TAG_WIDTH:0]   count_n;

   logic tag_live;
   logic restore_fire, bad_tag, take_fire, rel_fire, underflow;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] entries [DEPTH];

   ckpt_tag_live #(
      .DEPTH     (DEPTH),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_tag_live (
      .head  (head),
      .tail  (tail),
      .count (count),
      .tag   (restore_tag),
      .live  (tag_live)
   );

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // FSM next state: enter HOLD on a live restore, leave on ack.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (restore_valid && tag_live) state_n = HOLD;
         HOLD:    if (restore_ack)               state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // FSM outputs: allocation handshake and restore-valid indication.
   always_comb begin
      take_ready   = !full && (state == IDLE) && !restore_valid;
      take_tag     = tail;
      restore_done = (state == HOLD);
   end

   // Event decode and next pointer/count values for all simultaneous events.
   always_comb begin
      // NOTE: defaults first on every comb output so no path infers a latch.
      restore_fire = 1'b0;
      bad_tag      = 1'b0;
      if ((state == IDLE) && restore_valid) begin
         restore_fire = tag_live;
         bad_tag      = !tag_live;
      end
      take_fire = take_valid && take_ready;
      // Restoring the oldest entry discards it, so a same-cycle release has nothing left to free.
      rel_fire  = release_valid && !empty && !(restore_fire && (restore_tag == head));
      underflow = release_valid && empty;

      head_n  = rel_fire ? head + ONE_TAG : head;
      tail_n  = tail;
      count_n = count;
      if (restore_fire) begin
         // Survivors are the entries older than restore_tag, less any just released.
         tail_n  = restore_tag;
         count_n = {1'b0, restore_tag - head_n};
      end else begin
         if (take_fire) tail_n = tail + ONE_TAG;
         case ({take_fire, rel_fire})
            2'b10:   count_n = count + ONE_CNT;
            2'b01:   count_n = count - ONE_CNT;
            default: count_n = count;
         endcase
      end
   end

   // Pointers, restored image and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         regs_restore  <= '0;
         err_bad_tag   <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         head  <= head_n;
         tail  <= tail_n;
         count <= count_n;
         if (restore_fire) regs_restore  <= entries[restore_tag];
         if (bad_tag)      err_bad_tag   <= 1'b1;
         if (underflow)    err_underflow <= 1'b1;
      end
   end

   // Checkpoint storage: capture the live register file on an accepted take.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; slots are only read once live, and live implies written.
      if (take_fire) entries[tail] <= regs_in;
   end

endmodule

// File: tb/tb_register_checkpoint_buffer.sv
// Self-checking bench: directed walk through the main scenarios followed by
// random traffic, all compared against a queue-based model of live checkpoints.
module tb_register_checkpoint_buffer;
   import mips_core_pkg::*;

   localparam int DW    = DEF_DATA_WIDTH;
   localparam int NR    = DEF_NUM_REGS;
   localparam int DEPTH = DEF_DEPTH;
   localparam int TW    = DEF_TAG_WIDTH;
   localparam int CW    = DW * NR;

   logic           clk;
   logic           rst_n;
   regfile_t       regs_in;
   logic           take_valid;
   logic           take_ready;
   logic [TW-1:0]  take_tag;
   logic           release_valid;
   logic           restore_valid;
   logic [TW-1:0]  restore_tag;
   logic           restore_ack;
   logic           restore_done;
   regfile_t       regs_restore;
   logic [TW:0]    count;
   logic           full;
   logic           empty;
   logic           err_bad_tag;
   logic           err_underflow;

   register_checkpoint_buffer #(
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .DEPTH      (DEPTH),
      .TAG_WIDTH  (TW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .regs_in       (regs_in),
      .take_valid    (take_valid),
      .take_ready    (take_ready),
      .take_tag      (take_tag),
      .release_valid (release_valid),
      .restore_valid (restore_valid),
      .restore_tag   (restore_tag),
      .restore_ack   (restore_ack),
      .restore_done  (restore_done),
      .regs_restore  (regs_restore),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .err_bad_tag   (err_bad_tag),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: ordered list of live tags plus a per-tag data store.
   regfile_t m_mem [DEPTH];
   int       m_q[$];
   int       m_tail;
   bit       m_hold;
   regfile_t m_restore;
   bit       m_bad;
   bit       m_uf;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_tail    = 0;
      m_hold    = 1'b0;
      m_restore = '0;
      m_bad     = 1'b0;
      m_uf      = 1'b0;
   endfunction

   function automatic regfile_t mk_regs(input logic [DW-1:0] r5);
      regfile_t r;
      for (int i = 0; i < NR; i++) r[i] = DW'($urandom);
      r[5] = r5;
      return r;
   endfunction

   task automatic check_state();
      check("count",         CW'(count),         CW'(m_q.size()));
      check("full",          CW'(full),          CW'(m_q.size() == DEPTH));
      check("empty",         CW'(empty),         CW'(m_q.size() == 0));
      check("restore_done",  CW'(restore_done),  CW'(m_hold));
      check("regs_restore",  regs_restore,       m_restore);
      check("err_bad_tag",   CW'(err_bad_tag),   CW'(m_bad));
      check("err_underflow", CW'(err_underflow), CW'(m_uf));
   endtask

   // One clock of stimulus; entered and left 1 time unit after a rising edge.
   task automatic cycle(input bit tv, input bit relv, input bit rsv, input int rtag,
                        input bit ack, input regfile_t rin);
      bit exp_ready;
      bit was_empty;
      bit was_hold;
      int idx;
      take_valid    = tv;
      release_valid = relv;
      restore_valid = rsv;
      restore_tag   = TW'(rtag);
      restore_ack   = ack;
      regs_in       = rin;
      #1;
      exp_ready = (m_q.size() < DEPTH) && !m_hold && !rsv;
      check("take_ready", CW'(take_ready), CW'(exp_ready));
      check("take_tag",   CW'(take_tag),   CW'(m_tail));
      @(posedge clk);
      #1;
      was_empty = (m_q.size() == 0);
      was_hold  = m_hold;
      if (relv && was_empty) m_uf = 1'b1;
      if (!was_hold) begin
         if (rsv) begin
            idx = -1;
            foreach (m_q[i]) if (m_q[i] == rtag) idx = i;
            if (idx < 0) begin
               m_bad = 1'b1;
            end else begin
               m_restore = m_mem[rtag];
               while (m_q.size() > idx) void'(m_q.pop_back());
               m_tail = rtag;
               m_hold = 1'b1;
            end
         end
      end else if (ack) begin
         m_hold = 1'b0;
      end
      if (tv && exp_ready) begin
         m_mem[m_tail] = rin;
         m_q.push_back(m_tail);
         m_tail = (m_tail + 1) % DEPTH;
      end
      if (relv && !was_empty && m_q.size() > 0) void'(m_q.pop_front());
      check_state();
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'($urandom)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      regfile_t snap;
      regfile_t cap2;
      int       tags2[3];
      int       nonlive;

      rst_n         = 1'b0;
      take_valid    = 1'b0;
      release_valid = 1'b0;
      restore_valid = 1'b0;
      restore_tag   = '0;
      restore_ack   = 1'b0;
      regs_in       = '0;
      model_reset();
      #2;
      check_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill: tags 0..3 in order, then full blocks a fifth take.
      for (int i = 0; i < DEPTH; i++) begin
         check("tag_seq", CW'(take_tag), CW'(i));
         cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h10 + i)));
      end
      check("full_after_fill", CW'(full), CW'(1));
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h99)));
      check("count_stays_full", CW'(count), CW'(DEPTH));

      // Restore tag 1 from full, hold without ack, then ack.
      cycle(1'b0, 1'b0, 1'b1, 1, 1'b0, mk_regs(DW'(0)));
      check("restore_r5", CW'(regs_restore[5]), CW'(32'h11));
      check("restore_cnt", CW'(count), CW'(1));
      snap = regs_restore;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(0)));
         check("hold_stable", regs_restore, snap);
      end
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, mk_regs(DW'(0)));
      check("done_after_ack", CW'(restore_done), CW'(0));

      // Grow to two, release both, then underflow.
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h20)));
      cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, mk_regs(DW'(0)));
      cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, mk_regs(DW'(0)));
      check("empty_after_rel", CW'(empty), CW'(1));
      cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, mk_regs(DW'(0)));
      check("underflow_flag", CW'(err_underflow), CW'(1));
      check("underflow_cnt", CW'(count), CW'(0));

      // Wrap: take 3, release 3, take 3, restore the middle capture.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'($urandom)));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, mk_regs(DW'(0)));
      for (int i = 0; i < 3; i++) begin
         regfile_t r;
         r = mk_regs(DW'(32'h30 + i));
         tags2[i] = m_tail;
         if (i == 1) cap2 = r;
         cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, r);
      end
      check("wrap_tag0", CW'(tags2[0]), CW'((tags2[2] + DEPTH - 2) % DEPTH));
      cycle(1'b0, 1'b0, 1'b1, tags2[1], 1'b0, mk_regs(DW'(0)));
      check("wrap_restore", regs_restore, cap2);
      check("wrap_cnt", CW'(count), CW'(1));
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, mk_regs(DW'(0)));

      // Restore of head with a same-cycle release: release ignored.
      cycle(1'b0, 1'b1, 1'b1, tags2[0], 1'b0, mk_regs(DW'(0)));
      check("rst_head_cnt", CW'(count), CW'(0));
      check("rst_head_done", CW'(restore_done), CW'(1));
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, mk_regs(DW'(0)));

      // Restore and take in the same cycle: no allocation.
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h40)));
      cycle(1'b1, 1'b0, 1'b1, m_q[0], 1'b0, mk_regs(DW'(32'h41)));
      check("rst_take_cnt", CW'(count), CW'(0));
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, mk_regs(DW'(0)));

      // Restore of a non-live tag.
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h50)));
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h51)));
      nonlive = m_tail;
      cycle(1'b0, 1'b0, 1'b1, nonlive, 1'b0, mk_regs(DW'(0)));
      check("bad_tag_flag", CW'(err_bad_tag), CW'(1));
      check("bad_tag_done", CW'(restore_done), CW'(0));

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 12, $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 99) < 35, mk_regs(DW'($urandom)));
      end

      // Asynchronous reset while holding a restore.
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, mk_regs(DW'(0)));
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h60)));
      cycle(1'b0, 1'b0, 1'b1, m_q[0], 1'b0, mk_regs(DW'(0)));
      check("pre_reset_done", CW'(restore_done), CW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_done", CW'(restore_done), CW'(0));
      check("async_cnt", CW'(count), CW'(0));
      check_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, mk_regs(DW'(32'h70)));
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
